// File: rtl/uint_div_pkg.sv
// ---------------------------------------------------------------------------
// uint_div_pkg
// Shared types and constants for the sequential unsigned divider.
//   div_state_e : controller states (IDLE, RUN, DONE)
//   DVD_W_DEF   : default dividend / quotient width
//   DVS_W_DEF   : default divisor / remainder width
//   CNT_W_DEF   : step counter width for the default dividend width
// ---------------------------------------------------------------------------
package uint_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DVD_W_DEF = 16;
    localparam int DVS_W_DEF = 8;
    localparam int CNT_W_DEF = $clog2(DVD_W_DEF);

endpackage

// File: rtl/uint_div_step.sv
// ---------------------------------------------------------------------------
// uint_div_step
// One radix-2 restoring division step, purely combinational.
// Ports:
//   rem      in  DVS_W  partial remainder entering the step
//   dvd_msb  in  1      next dividend bit shifted into the remainder
//   divisor  in  DVS_W  divisor
//   rem_next out DVS_W  partial remainder leaving the step
//   qbit     out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module uint_div_step #(
    parameter int DVS_W = 8
) (
    input  logic [DVS_W-1:0] rem,
    input  logic             dvd_msb,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W-1:0] rem_next,
    output logic             qbit
);

    logic [DVS_W:0] cand;
    logic [DVS_W:0] diff;

    // The extra top bit keeps the comparison exact; since rem < divisor on
    // entry, the difference always fits back into DVS_W bits.
    assign cand     = {rem, dvd_msb};
    assign diff     = cand - {1'b0, divisor};
    assign qbit     = (cand >= {1'b0, divisor});
    assign rem_next = qbit ? diff[DVS_W-1:0] : cand[DVS_W-1:0];

endmodule

// File: rtl/uint_divider16.sv
// ---------------------------------------------------------------------------
// uint_divider16
// Sequential unsigned divider, one quotient bit per cycle (restoring).
// Optional build macro: UINT_DIVIDER16_DBZ_FAST_EN -- divide-by-zero skips
// the iteration and completes straight from IDLE with identical results.
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   in_valid      operands present        in_ready   idle, can accept
//   dividend      DVD_W-bit dividend      divisor    DVS_W-bit divisor
//   out_valid     result present          out_ready  consumer accepts
//   quotient      DVD_W-bit quotient      remainder  DVS_W-bit remainder
//   div_by_zero   divisor was 0 for the presented result
// ---------------------------------------------------------------------------
module uint_divider16
    import uint_div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(DVD_W);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [DVD_W-1:0] dvd_q;     // dividend shifts out the top, quotient in the bottom
    logic [DVS_W-1:0] rem_q;
    logic [DVS_W-1:0] dvs_q;
    logic             dbz_q;
    logic [DVD_W-1:0] quot_out_q;
    logic [DVS_W-1:0] rem_out_q;
    logic             dbz_out_q;

    logic [DVS_W-1:0] rem_next;
    logic             qbit;

    uint_div_step #(.DVS_W(DVS_W)) u_step (
        .rem      (rem_q),
        .dvd_msb  (dvd_q[DVD_W-1]),
        .divisor  (dvs_q),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef UINT_DIVIDER16_DBZ_FAST_EN
                    state_d = (divisor == '0) ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN:     if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dvs_q      <= '0;
            dbz_q      <= 1'b0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_out_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q <= dividend;
                        dvs_q <= divisor;
                        rem_q <= '0;
                        cnt_q <= CNT_W'(DVD_W - 1);
                        dbz_q <= (divisor == '0);
`ifdef UINT_DIVIDER16_DBZ_FAST_EN
                        // Same values the full iteration would reach with a zero divisor.
                        if (divisor == '0) begin
                            quot_out_q <= '1;
                            rem_out_q  <= dividend[DVS_W-1:0];
                            dbz_out_q  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    rem_q <= rem_next;
                    dvd_q <= {dvd_q[DVD_W-2:0], qbit};
                    if (cnt_q == '0) begin
                        // Result registers only move on completion so the
                        // outputs hold steady through IDLE and RUN.
                        quot_out_q <= {dvd_q[DVD_W-2:0], qbit};
                        rem_out_q  <= rem_next;
                        dbz_out_q  <= dbz_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_out_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dbz_out_q;

endmodule
